// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready handshake blocks: default beat width
// and pointer-comparison helpers used by register slices and FIFOs.
package hs_pkg;

    localparam int HS_WIDTH = 8;

    // Pointers carry one extra wrap bit above the index. Callers zero-extend
    // them to 32 bits and pass the index width.
    function automatic logic is_full(input logic [31:0] wr_ptr,
                                     input logic [31:0] rd_ptr,
                                     input int          aw);
        return (wr_ptr ^ rd_ptr) == (32'd1 << aw);
    endfunction

    function automatic logic is_empty(input logic [31:0] wr_ptr,
                                      input logic [31:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module hs_fifo_mem
    import hs_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_sync_fifo.sv
// First-word-fall-through valid/ready FIFO placed after a register slice.
// Occupancy and flags are derived from wrap-bit pointers.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter  int WIDTH = HS_WIDTH,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m_data,
    output logic             m_ready,
    output logic             s_valid,
    output logic [WIDTH-1:0] s_data,
    input  logic             s_ready,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        rdy_en_q, rdy_en_d;
    logic        push, pop;

    assign full    = is_full(32'(wr_ptr_q), 32'(rd_ptr_q), AW);
    assign empty   = is_empty(32'(wr_ptr_q), 32'(rd_ptr_q));
    assign count   = wr_ptr_q - rd_ptr_q;

    // rdy_en_q keeps m_ready low while reset is held and for no longer.
    assign m_ready = rdy_en_q & ~full;
    assign s_valid = ~empty;
    assign push    = m_valid & m_ready;
    assign pop     = s_valid & s_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdy_en_d = 1'b1;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    hs_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (m_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (s_data)
    );

endmodule

// File: tb/tb_hs_sync_fifo.sv
// Scoreboard bench for hs_sync_fifo with WIDTH=8, DEPTH=4.
module tb_hs_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_ready;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready = 1'b0;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int total = 0;
    int bad   = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    hs_sync_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    task automatic test_reset();
        rst_n = 1'b0; m_valid = 1'b0; s_ready = 1'b0;
        #12;
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL rst_m_ready: got %b want 0", m_ready); end
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rst_s_valid: got %b want 0", s_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", full); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL post_rst_m_ready: got %b want 1", m_ready); end
        total++; if (empty !== 1'b1 || full !== 1'b0 || s_valid !== 1'b0 || count !== 3'd0) begin
            bad++; $display("FAIL post_rst_flags: got empty=%b full=%b s_valid=%b count=%0d want 1 0 0 0",
                            empty, full, s_valid, count);
        end
        q.delete();
    endtask

    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        s_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_valid = 1'b1; m_data = vals[i];
            q.push_back(vals[i]);
            @(posedge clk); #1;
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            total++; if (s_valid !== 1'b1 || s_data !== 8'h11) begin
                bad++; $display("FAIL fill_head[%0d]: got v=%b d=%h want v=1 d=11", i, s_valid, s_data);
            end
        end
        total++; if (full !== 1'b1 || m_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full: got full=%b m_ready=%b want 1 0", full, m_ready);
        end
        m_data = 8'h55;
        @(posedge clk); #1;
        total++; if (count !== 3'd4 || s_data !== 8'h11) begin
            bad++; $display("FAIL fill_hold: got count=%0d d=%h want 4 11", count, s_data);
        end
    endtask

    task automatic test_drain_from_full();
        logic [7:0] exp;
        s_ready = 1'b1;
        exp = q.pop_front();
        total++; if (s_data !== exp) begin bad++; $display("FAIL pop_full_data: got %h want %h", s_data, exp); end
        @(posedge clk); #1;
        s_ready = 1'b0;
        total++; if (count !== 3'd3 || m_ready !== 1'b1) begin
            bad++; $display("FAIL pop_full_after: got count=%0d m_ready=%b want 3 1", count, m_ready);
        end
        q.push_back(8'h55);
        @(posedge clk); #1;
        m_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL accept_55_count: got %0d want 4", count); end
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = q.pop_front();
            total++; if (s_valid !== 1'b1 || s_data !== exp) begin
                bad++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, s_valid, s_data, exp);
            end
            @(posedge clk); #1;
        end
        s_ready = 1'b0;
        total++; if (empty !== 1'b1 || count !== 3'd0) begin
            bad++; $display("FAIL drain_empty: got empty=%b count=%0d want 1 0", empty, count);
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp;
        for (int i = 0; i <= 20; i++) begin
            m_valid = (i < 20); m_data = 8'(i); s_ready = 1'b1;
            if (q.size() > 0) begin
                exp = q.pop_front();
                total++; if (s_valid !== 1'b1 || s_data !== exp) begin
                    bad++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, s_valid, s_data, exp);
                end
            end
            if (i < 20) q.push_back(8'(i));
            @(posedge clk); #1;
            total++; if (count !== 3'(q.size()) || (i < 20 && count !== 3'd1)) begin
                bad++; $display("FAIL stream_count[%0d]: got %0d want %0d", i, count, q.size());
            end
        end
        m_valid = 1'b0; s_ready = 1'b0;
    endtask

    task automatic test_random();
        int   sent = 0, rcvd = 0, cyc = 0, sz;
        logic pend = 1'b0;
        logic [7:0] exp;
        while (rcvd < 1000 && cyc < 20000) begin
            if (!pend) begin
                m_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
                m_data  = 8'($urandom);
            end
            s_ready = 1'($urandom_range(0, 1));
            sz = q.size();
            total++; if (count !== 3'(sz)) begin bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", cyc, count, sz); end
            total++; if (m_ready !== (sz < 4) || s_valid !== (sz != 0)) begin
                bad++; $display("FAIL rnd_flags[%0d]: got m_ready=%b s_valid=%b want %b %b", cyc, m_ready, s_valid, sz < 4, sz != 0);
            end
            if (s_ready && sz > 0) begin
                exp = q.pop_front();
                rcvd++;
                total++; if (s_data !== exp) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, s_data, exp); end
            end
            if (m_valid && sz < 4) begin
                q.push_back(m_data);
                sent++;
                pend = 1'b0;
            end else begin
                pend = m_valid;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_valid = 1'b0; s_ready = 1'b0;
        total++; if (rcvd != 1000) begin bad++; $display("FAIL rnd_timeout: got %0d beats want 1000", rcvd); end
    endtask

    task automatic test_async_reset();
        s_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1; m_data = 8'hA1 + 8'(i);
            @(posedge clk); #1;
        end
        m_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL ar_pre_count: got %0d want 3", count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (s_valid !== 1'b0 || full !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || m_ready !== 1'b0) begin
            bad++; $display("FAIL ar_clear: got v=%b full=%b count=%0d empty=%b m_ready=%b want 0 0 0 1 0",
                            s_valid, full, count, empty, m_ready);
        end
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (empty !== 1'b1 || m_ready !== 1'b1) begin
            bad++; $display("FAIL ar_release: got empty=%b m_ready=%b want 1 1", empty, m_ready);
        end
        m_valid = 1'b1; m_data = 8'hA5;
        @(posedge clk); #1;
        m_valid = 1'b0;
        total++; if (s_valid !== 1'b1 || s_data !== 8'hA5 || count !== 3'd1) begin
            bad++; $display("FAIL ar_first: got v=%b d=%h count=%0d want 1 a5 1", s_valid, s_data, count);
        end
        s_ready = 1'b1;
        @(posedge clk); #1;
        s_ready = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ar_drained: got empty=%b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_from_full();
        test_stream();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_sync_fifo.md
Name: hs_sync_fifo

Overview:
- Parameterised valid/ready synchronous FIFO, first-word-fall-through.
- Sits directly downstream of a register slice (forward, backward or fully registered) and feeds the slave consumer.
- Absorbs consumer back-pressure bursts that a single-entry slice cannot. Exposes occupancy for debug and flow monitoring.

Parameters:
- WIDTH, 8, data bits per beat.
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- m_valid  input  1  upstream beat valid.
- m_data  input  WIDTH  upstream beat data.
- m_ready  output  1  FIFO can accept a beat.
- s_valid  output  1  head entry valid toward consumer.
- s_data  output  WIDTH  head entry data.
- s_ready  input  1  consumer accepts the head beat.
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset is asynchronous and active-low. Assertion of rst_n=0 immediately clears the following:
  - write pointer, read pointer and count become 0;
  - m_ready=0 while reset is asserted, then 1 from the first cycle after deassertion;
  - s_valid=0, empty=1, full=0.
- Storage array is not reset. s_data is don't-care while s_valid=0.
- Pointers are AW+1 bits wide; the MSB is the wrap bit.
  - full when the index bits are equal and the wrap bits differ.
  - empty when the pointers are fully equal.
- push = m_valid & m_ready, with m_ready = ~full (registered-state based, no combinational path from s_ready).
- pop = s_valid & s_ready, with s_valid = ~empty.
- s_data = mem[rd_ptr index], read combinationally (FWFT).
- Latency: a beat pushed at edge N is visible on s_valid/s_data after edge N, so it can be popped at edge N+1. There is no same-cycle bypass when empty.
- Push only: write mem[wr index], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any occupancy except:
  - when full, push is blocked (m_ready=0), so only pop occurs;
  - when empty, pop is impossible (s_valid=0), so only push occurs.
- Full, with s_ready high: m_ready stays 0 that cycle. It rises the cycle after the pop.
- Pointer wrap: the index wraps from DEPTH-1 to 0 and the wrap bit toggles. Order is preserved across the wrap.
- m_data is ignored when push=0. The FIFO never drops or duplicates a beat.
- Protocol rule: upstream must hold m_valid/m_data stable until accepted. The FIFO holds s_valid/s_data stable until popped.
- Reset mid-operation: all contents are discarded, and the outputs return to their reset values asynchronously.
- count, full and empty are derived from the pointers. They are consistent with m_ready/s_valid in every cycle.

Decomposition:
- Shared package hs_pkg:
  - default WIDTH constant;
  - pointer-compare helper functions (is_full, is_empty) reused by the register slices and this FIFO.
- One natural sub-module: hs_fifo_mem, a simple dual-port register array with synchronous write and asynchronous read.
- Pointer and flag logic stay in hs_sync_fifo.

Test Plan:
1. Reset, then idle, with WIDTH=8, DEPTH=4 -> empty=1, full=0, count=0, s_valid=0, m_ready=1 on the first post-reset cycle.
2. Push 0x11,0x22,0x33,0x44 with s_ready=0 -> count 1,2,3,4; full=1, m_ready=0 after the 4th edge; s_data=0x11 throughout. A 5th m_valid beat 0x55 is held and not accepted.
3. From full, raise s_ready for 1 cycle -> 0x11 popped, count=3. m_ready=1 next cycle, and 0x55 is accepted on the following edge. Subsequent reads return 0x22,0x33,0x44,0x55.
4. Continuous streaming with m_valid=s_ready=1 for 20 beats, data 0..19 -> after a 1-cycle fill, count stays 1. Output is 0..19 in order across multiple pointer wraps, with no gaps.
5. Random m_valid/s_ready (50% each) for 1000 beats against a scoreboard queue -> order exact, no loss or duplication, count always 0..4 and matching the model.
6. Assert rst_n=0 mid-stream at count=3 (asynchronously, between edges) -> s_valid, full and count clear immediately. After release, empty=1, and the first new push 0xA5 is the first beat out.
